// File: rtl/src_arbiter_if.sv
// Source-arbiter bus: per-source FIFO side plus granted-packet encoder side.
// The master modport is the arbiter and the slave modport is the sources and encoder.
interface src_arbiter_if #(
   parameter int N_SRC = 4
);
   localparam int SW = $clog2(N_SRC);

   logic [N_SRC-1:0]   have_msg_bus;
   logic [8*N_SRC-1:0] len_bus;
   logic [8*N_SRC-1:0] data_bus;
   logic [N_SRC-1:0]   rdreq_bus;
   logic [N_SRC-1:0]   en_mask;
   logic [N_SRC-1:0]   prio_mask;
   logic               out_have_msg;
   logic [SW-1:0]      out_src;
   logic [7:0]         out_len;
   logic [7:0]         out_data;
   logic               out_rdreq;
   logic               timeout_err;
   logic               zero_len_err;

   modport master (
      input  have_msg_bus, len_bus, data_bus,
      input  en_mask, prio_mask, out_rdreq,
      output rdreq_bus, out_have_msg, out_src,
      output out_len, out_data,
      output timeout_err, zero_len_err
   );

   modport slave (
      output have_msg_bus, len_bus, data_bus,
      output en_mask, prio_mask, out_rdreq,
      input  rdreq_bus, out_have_msg, out_src,
      input  out_len, out_data,
      input  timeout_err, zero_len_err
   );
endinterface

// File: rtl/src_arbiter.sv
// Packet source arbiter: two-level priority with age promotion,
// round-robin within the winning group, and a read watchdog per grant.
module src_arbiter #(
   parameter int N_SRC     = 4,
   parameter int AGE_LIMIT = 64,
   parameter int TIMEOUT   = 1024
) (
   input logic         clk,
   input logic         n_rst,
   src_arbiter_if.master bus
);
   localparam int SW = $clog2(N_SRC);
   localparam int AW = $clog2(AGE_LIMIT + 1);
   localparam int WW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [SW-1:0] rr_ptr;
   logic [SW-1:0] src_q;
   logic [SW-1:0] sel;
   logic [SW-1:0] idx;
   logic [7:0]    len_q;
   logic [7:0]    cnt;
   logic [WW-1:0] wdog;
   logic [AW-1:0] age [N_SRC];

   logic [N_SRC-1:0] elig;
   logic [N_SRC-1:0] hi;
   logic [N_SRC-1:0] cand;
   logic [N_SRC-1:0] held;
   logic             found;
   logic             grant;
   logic             zl_hit;
   logic             rd_ok;
   logic             last_rd;
   logic             to_hit;

   // An aged source joins the high group, so it can beat fresh low sources.
   always_comb begin
      elig  = bus.have_msg_bus & bus.en_mask;
      hi    = '0;
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int i = 0; i < N_SRC; i++) begin
         hi[i] = elig[i] &
                 (bus.prio_mask[i] | (age[i] == AW'(AGE_LIMIT)));
      end
      cand = (|hi) ? hi : elig;
      for (int k = 0; k < N_SRC; k++) begin
         idx = SW'((int'(rr_ptr) + k) % N_SRC);
         if (!found && cand[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   always_comb begin
      grant   = (state == IDLE) && found;
      zl_hit  = (state == GRANT) && (len_q == 8'd0);
      rd_ok   = (state == GRANT) && !zl_hit && bus.out_rdreq;
      last_rd = rd_ok && (cnt == len_q - 8'd1);
      to_hit  = (state == GRANT) && !zl_hit && !bus.out_rdreq &&
                (wdog == WW'(TIMEOUT - 1));
      held    = '0;
      for (int i = 0; i < N_SRC; i++) begin
         held[i] = (grant && (sel == SW'(i))) ||
                   ((state == GRANT) && (src_q == SW'(i)));
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (found) state_nx = GRANT;
         GRANT:   if (zl_hit || last_rd || to_hit) state_nx = GAP;
         GAP:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state  <= IDLE;
         rr_ptr <= '0;
         src_q  <= '0;
         len_q  <= '0;
         cnt    <= '0;
         wdog   <= '0;
         for (int i = 0; i < N_SRC; i++) age[i] <= '0;
      end else begin
         state <= state_nx;
         if (grant) begin
            src_q  <= sel;
            len_q  <= bus.len_bus[8*sel +: 8];
            cnt    <= '0;
            wdog   <= '0;
            rr_ptr <= (sel == SW'(N_SRC - 1)) ? '0 : sel + SW'(1);
         end else if (state == GRANT) begin
            if (rd_ok) cnt <= cnt + 8'd1;
            if (bus.out_rdreq) wdog <= '0;
            else if (!to_hit) wdog <= wdog + WW'(1);
         end
         for (int i = 0; i < N_SRC; i++) begin
            if (elig[i] && !held[i]) begin
               if (age[i] != AW'(AGE_LIMIT)) age[i] <= age[i] + AW'(1);
            end else begin
               age[i] <= '0;
            end
         end
      end
   end

   assign bus.out_have_msg = (state == GRANT);
   assign bus.rdreq_bus    = rd_ok ? (N_SRC'(1) << src_q) : '0;
   assign bus.out_src      = src_q;
   assign bus.out_len      = len_q;
   assign bus.out_data     = bus.data_bus[8*src_q +: 8];
   assign bus.timeout_err  = to_hit;
   assign bus.zero_len_err = zl_hit;
endmodule

// File: doc/src_arbiter.md
SRC_ARBITER -- requirements
Module: src_arbiter

Interface
REQ-001 SHALL have parameters: N_SRC, 4, number of sources (>=2); AGE_LIMIT, 64, wait cycles before a low-priority source is promoted; TIMEOUT, 1024, idle-read cycles before a grant is aborted.
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: n_rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: have_msg_bus  in  N_SRC  per-source packet-ready flag.
REQ-005 SHALL have port: len_bus  in  8*N_SRC  per-source packet length in bytes.
REQ-006 SHALL have port: data_bus  in  8*N_SRC  per-source show-ahead FIFO data.
REQ-007 SHALL have port: rdreq_bus  out  N_SRC  per-source FIFO read strobe.
REQ-008 SHALL have port: en_mask  in  N_SRC  source enable; 0 = never granted.
REQ-009 SHALL have port: prio_mask  in  N_SRC  1 = high-priority group.
REQ-010 SHALL have port: out_have_msg  out  1  granted packet available to encoder.
REQ-011 SHALL have port: out_src  out  clog2(N_SRC)  granted source index.
REQ-012 SHALL have port: out_len  out  8  latched length of granted packet.
REQ-013 SHALL have port: out_data  out  8  data_bus slice of granted source.
REQ-014 SHALL have port: out_rdreq  in  1  encoder read strobe.
REQ-015 SHALL have port: timeout_err  out  1  one-cycle pulse on grant abort.
REQ-016 SHALL have port: zero_len_err  out  1  one-cycle pulse on zero-length grant.

Function
REQ-017 SHALL implement states IDLE, GRANT, GAP; encoding 2 bits.
REQ-018 Eligible source: have_msg_bus[i] & en_mask[i]; effective-high: prio_mask[i] | age[i]==AGE_LIMIT.
REQ-019 IDLE: if any eligible, SHALL select among effective-high first, else among all eligible, round-robin starting at rr_ptr; register out_src, out_len <= len_bus slice, cnt <= 0, go GRANT next cycle (request-to-grant latency 1 cycle).
REQ-020 After each grant, rr_ptr SHALL become granted index + 1, wrapping N_SRC-1 -> 0.
REQ-021 GRANT: out_have_msg = 1; rdreq_bus = out_rdreq one-hot at out_src, combinational, zero elsewhere; each out_rdreq increments cnt.
REQ-022 GRANT SHALL exit to GAP on the cycle out_rdreq occurs with cnt == out_len-1; later reads SHALL NOT reach rdreq_bus.
REQ-023 out_len == 0: SHALL go GAP after one GRANT cycle, no rdreq issued, zero_len_err pulse in that cycle.
REQ-024 GAP: exactly one cycle, out_have_msg = 0, rdreq_bus = 0, then IDLE.
REQ-025 out_data SHALL equal data_bus[8*out_src+:8] in every state.
REQ-026 Deassertion of have_msg_bus, en_mask or prio_mask during GRANT SHALL NOT end the grant.
REQ-027 Watchdog: in GRANT, idle counter counts cycles without out_rdreq, cleared on out_rdreq; at TIMEOUT-1 SHALL go GAP and pulse timeout_err.
REQ-028 age[i] (saturating at AGE_LIMIT) SHALL increment each cycle source i is eligible and not granted, clear when granted or not eligible.
REQ-029 Simultaneous eligible requests: one grant only; no source starved beyond (N_SRC-1) packets within its group.
REQ-030 Outside GRANT, rdreq_bus SHALL be 0 and out_have_msg 0.

Reset
REQ-031 On clk edge with n_rst=0: state IDLE, rr_ptr 0, out_src 0, out_len 0, cnt 0, ages 0, watchdog 0, timeout_err 0, zero_len_err 0, out_have_msg 0, rdreq_bus 0.
REQ-032 Reset mid-GRANT SHALL abandon packet with no further rdreq; first grant after reset starts search at index 0.

Verification
REQ-033 Sources 0,2 ready, len 3, all low-prio -> grant 0, 3 rdreq_bus[0] pulses, GAP, grant 2; rr_ptr 3.
REQ-034 Source 1 low, source 3 high, both ready -> source 3 granted first; after source 1 waits 64 cycles it beats non-aged low sources.
REQ-035 Grant len 2, encoder issues 4 reads -> exactly 2 rdreq_bus pulses, out_have_msg low next cycle.
REQ-036 Grant len 5, no out_rdreq for 1024 cycles -> timeout_err single pulse, GAP, IDLE.
REQ-037 len 0 on source 2 -> zero_len_err pulse, no rdreq, rr_ptr 3; en_mask[1]=0 with have_msg -> never granted.
